// File: rtl/ball_vga_render.sv
// VGA renderer for the bouncing ball: raw timing, tear-free per-frame position
// latch, and a three-stage distance/colour pipeline with delay-matched syncs.
module ball_vga_render #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int BALL_X   = 320,
   parameter int RADIUS   = 8,
   parameter int TOP      = 20,
   parameter int BOTTOM   = 310
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [16:0] position,
   input  logic [8:0]  handline,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [11:0] rgb,
   output logic        frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_BEG    = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VS_BEG    = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [16:0] POS_MAX   = 17'(V_ACTIVE - 1);
   localparam logic [9:0]  ROW_MAX   = 10'(V_ACTIVE - 1);
   localparam logic [16:0] POS_RST   = 17'(BOTTOM);
   localparam logic [9:0]  FPOS_RST  = 10'(BOTTOM);
   localparam logic [10:0] BX        = 11'(BALL_X);
   localparam logic [21:0] R_SQ      = 22'(RADIUS * RADIUS);
   localparam logic [9:0]  ROW_CEIL  = 10'(TOP - RADIUS);
   localparam logic [9:0]  ROW_FLOOR = 10'(BOTTOM + RADIUS);

   localparam logic [11:0] C_OFF  = 12'h000;
   localparam logic [11:0] C_BALL = 12'hF00;
   localparam logic [11:0] C_HAND = 12'h0F0;
   localparam logic [11:0] C_WALL = 12'hFFF;
   localparam logic [11:0] C_BG   = 12'h003;

   logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [16:0] pos_m_q, pos_m_d, pos_s_q, pos_s_d, pos_p_q, pos_p_d;
   logic [16:0] stable_pos_q, stable_pos_d;
   logic [8:0]  hand_m_q, hand_m_d, hand_s_q, hand_s_d, hand_p_q, hand_p_d;
   logic [8:0]  stable_hand_q, stable_hand_d;
   logic [9:0]  frame_pos_q, frame_pos_d;
   logic [8:0]  frame_hand_q, frame_hand_d;
   logic        frame_start_q, frame_start_d;
   logic [10:0] dx1_q, dx1_d, dy1_q, dy1_d;
   logic        hand1_q, hand1_d, wall1_q, wall1_d;
   logic        de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
   logic [21:0] sq2_q, sq2_d;
   logic        hand2_q, hand2_d, wall2_q, wall2_d;
   logic        de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
   logic [11:0] rgb_q, rgb_d;
   logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;

   logic        latch;
   logic [10:0] hx, vy, fy;
   logic [21:0] dxw, dyw;

   always_comb begin
      h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST)
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;

      // Only accept a synchronised value once it has held for two cycles
      pos_m_d       = position;
      pos_s_d       = pos_m_q;
      pos_p_d       = pos_s_q;
      stable_pos_d  = (pos_s_q == pos_p_q) ? pos_s_q : stable_pos_q;
      hand_m_d      = handline;
      hand_s_d      = hand_m_q;
      hand_p_d      = hand_s_q;
      stable_hand_d = (hand_s_q == hand_p_q) ? hand_s_q : stable_hand_q;

      latch         = (h_cnt_q == '0) && (v_cnt_q == V_ACT);
      frame_start_d = latch;
      frame_pos_d   = frame_pos_q;
      frame_hand_d  = frame_hand_q;
      if (latch) begin
         frame_pos_d  = (stable_pos_q > POS_MAX) ? ROW_MAX : stable_pos_q[9:0];
         frame_hand_d = stable_hand_q;
      end

      hx      = {1'b0, h_cnt_q};
      vy      = {1'b0, v_cnt_q};
      fy      = {1'b0, frame_pos_q};
      dx1_d   = (hx >= BX) ? hx - BX : BX - hx;
      dy1_d   = (vy >= fy) ? vy - fy : fy - vy;
      hand1_d = (frame_hand_q != '0) && (v_cnt_q == {1'b0, frame_hand_q});
      wall1_d = (v_cnt_q == ROW_CEIL) || (v_cnt_q == ROW_FLOOR);
      de1_d   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs1_d   = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
      vs1_d   = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));

      dxw     = {11'b0, dx1_q};
      dyw     = {11'b0, dy1_q};
      sq2_d   = dxw * dxw + dyw * dyw;
      hand2_d = hand1_q;
      wall2_d = wall1_q;
      de2_d   = de1_q;
      hs2_d   = hs1_q;
      vs2_d   = vs1_q;

      if (!de2_q)
         rgb_d = C_OFF;
      else if (sq2_q <= R_SQ)
         rgb_d = C_BALL;
      else if (hand2_q)
         rgb_d = C_HAND;
      else if (wall2_q)
         rgb_d = C_WALL;
      else
         rgb_d = C_BG;
      de_d    = de2_q;
      hsync_d = hs2_q;
      vsync_d = vs2_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         pos_m_q       <= '0;
         pos_s_q       <= '0;
         pos_p_q       <= '0;
         stable_pos_q  <= POS_RST;
         hand_m_q      <= '0;
         hand_s_q      <= '0;
         hand_p_q      <= '0;
         stable_hand_q <= '0;
         frame_pos_q   <= FPOS_RST;
         frame_hand_q  <= '0;
         frame_start_q <= 1'b0;
         dx1_q         <= '0;
         dy1_q         <= '0;
         hand1_q       <= 1'b0;
         wall1_q       <= 1'b0;
         de1_q         <= 1'b0;
         hs1_q         <= 1'b1;
         vs1_q         <= 1'b1;
         sq2_q         <= '0;
         hand2_q       <= 1'b0;
         wall2_q       <= 1'b0;
         de2_q         <= 1'b0;
         hs2_q         <= 1'b1;
         vs2_q         <= 1'b1;
         rgb_q         <= '0;
         de_q          <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         pos_m_q       <= pos_m_d;
         pos_s_q       <= pos_s_d;
         pos_p_q       <= pos_p_d;
         stable_pos_q  <= stable_pos_d;
         hand_m_q      <= hand_m_d;
         hand_s_q      <= hand_s_d;
         hand_p_q      <= hand_p_d;
         stable_hand_q <= stable_hand_d;
         frame_pos_q   <= frame_pos_d;
         frame_hand_q  <= frame_hand_d;
         frame_start_q <= frame_start_d;
         dx1_q         <= dx1_d;
         dy1_q         <= dy1_d;
         hand1_q       <= hand1_d;
         wall1_q       <= wall1_d;
         de1_q         <= de1_d;
         hs1_q         <= hs1_d;
         vs1_q         <= vs1_d;
         sq2_q         <= sq2_d;
         hand2_q       <= hand2_d;
         wall2_q       <= wall2_d;
         de2_q         <= de2_d;
         hs2_q         <= hs2_d;
         vs2_q         <= vs2_d;
         rgb_q         <= rgb_d;
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign rgb         = rgb_q;
   assign frame_start = frame_start_q;
endmodule
